peripheral_hub: RTL and testbench

Memory-mapped peripheral controller that connects the CPU data bus to the keypad and the multi-digit seven-segment display. Keypad events are buffered in a parametrised FIFO so key presses are not lost between CPU polls. Display digits are held in an addressable register bank with auto-incrementing writes. Bus reads are registered, with one-cycle latency.

---
 rtl/peripheral_hub_pkg.sv | 32 +++
 rtl/key_fifo.sv | 65 ++++++
 rtl/peripheral_hub.sv | 188 ++++++++++++++++++
 tb/tb_peripheral_hub.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_hub_pkg.sv
// peripheral_hub_pkg
//   Shared constants for the keypad / seven-segment peripheral hub:
//   register word addresses, STATUS and CTRL bit positions, the KEY
//   valid-bit position and the all-segments-off pattern.
package peripheral_hub_pkg;

   // Register word addresses
   localparam int ADDR_KEY    = 0;
   localparam int ADDR_STATUS = 1;
   localparam int ADDR_DSEL   = 2;
   localparam int ADDR_DDATA  = 3;
   localparam int ADDR_DOT    = 4;
   localparam int ADDR_CTRL   = 5;

   // STATUS bit positions
   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVF       = 2;
   localparam int STAT_IRQ_EN    = 3;
   localparam int STAT_COUNT_LSB = 8;

   // CTRL bit positions
   localparam int CTRL_FLUSH = 0;
   localparam int CTRL_BLANK = 1;

   // KEY read data: set when a code was actually popped
   localparam int KEY_VALID_BIT = 8;

   // Segments are active-low, so all ones turns a digit off
   localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/key_fifo.sv
// key_fifo
//   Small synchronous FIFO buffering keypad events between CPU polls.
//   Read data is combinational from the head entry; the consumer registers it.
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     push_i/din_i   write an entry (ignored when full unless popping too)
//     pop_i          drop the head entry (ignored when empty)
//     flush_i        empty the FIFO; overrides push and pop
//     dout_o         head entry
//     empty_o/full_o occupancy flags
//     count_o        number of entries, one bit wider than the pointers
module key_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           din_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full FIFO still accepts
   // a simultaneous push. Flush discards everything, including this cycle.
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign do_push = push_i & ~flush_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/peripheral_hub.sv
// peripheral_hub
//   Memory-mapped bridge between the CPU data bus, the keypad scanner and a
//   multi-digit seven-segment display. Reads are registered (one cycle).
//   Optional feature macro: PERIPH_IRQ_EN adds the irq output and the
//   STATUS irq_enable bit.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     address, din          bus word address and write data
//     writeEnable           one-cycle write strobe
//     readEnable            one-cycle read strobe
//     dout                  registered read data, 0 when no read pending
//     key_valid, key_code   keypad event pulse and code
//     segs                  digit i on [8i+7:8i], active-low
//     dot                   decimal point, active-high
//     irq                   (PERIPH_IRQ_EN only) key available interrupt
module peripheral_hub
   import peripheral_hub_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 3,
   parameter int N_DIGITS   = 11,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     din,
   input  logic                  writeEnable,
   input  logic                  readEnable,
   output logic [DATA_W-1:0]     dout,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   output logic [8*N_DIGITS-1:0] segs,
   output logic                  dot
`ifdef PERIPH_IRQ_EN
   ,
   output logic                  irq
`endif
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int DSEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   logic [DATA_W-1:0]     dout_q;
   logic [DATA_W-1:0]     rdata_d;
   logic                  ovf_q;
   logic [DSEL_W-1:0]     dsel_q;
   logic                  dot_q;
   logic                  blank_q;
   logic                  irq_en;
   logic [8*N_DIGITS-1:0] digits_flat;

   logic                  fifo_empty;
   logic                  fifo_full;
   logic [CNT_W-1:0]      fifo_count;
   logic [3:0]            fifo_dout;

   // Address decode and strobes
   logic sel_key, sel_status, sel_dsel, sel_ddata, sel_dot, sel_ctrl;
   assign sel_key    = (address == ADDR_W'(ADDR_KEY));
   assign sel_status = (address == ADDR_W'(ADDR_STATUS));
   assign sel_dsel   = (address == ADDR_W'(ADDR_DSEL));
   assign sel_ddata  = (address == ADDR_W'(ADDR_DDATA));
   assign sel_dot    = (address == ADDR_W'(ADDR_DOT));
   assign sel_ctrl   = (address == ADDR_W'(ADDR_CTRL));

   logic wr_status, wr_dsel, wr_ddata, wr_dot, wr_ctrl, key_pop, flush;
   assign wr_status = writeEnable & sel_status;
   assign wr_dsel   = writeEnable & sel_dsel;
   assign wr_ddata  = writeEnable & sel_ddata;
   assign wr_dot    = writeEnable & sel_dot;
   assign wr_ctrl   = writeEnable & sel_ctrl;
   assign key_pop   = readEnable & sel_key & ~fifo_empty;
   assign flush     = wr_ctrl & din[CTRL_FLUSH];

   // A push is only lost when nothing frees a slot this cycle; a flush
   // drops the event deliberately and is not an overflow.
   logic ovf_set;
   assign ovf_set = key_valid & fifo_full & ~key_pop & ~flush;

   key_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (4)
   ) u_key_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (key_valid),
      .pop_i   (key_pop),
      .flush_i (flush),
      .din_i   (key_code),
      .dout_o  (fifo_dout),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_count)
   );

   // Digit registers, one per display position
   genvar gi;
   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         logic [7:0] digit_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               digit_q <= SEG_BLANK;
            end else if (wr_ddata && dsel_q == DSEL_W'(gi)) begin
               digit_q <= din[7:0];
            end
         end
         assign digits_flat[8*gi +: 8] = digit_q;
         assign segs[8*gi +: 8]        = blank_q ? SEG_BLANK : digit_q;
      end
   endgenerate

`ifdef PERIPH_IRQ_EN
   logic irq_en_q;
   logic irq_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_status) irq_en_q <= din[STAT_IRQ_EN];
         irq_q <= irq_en_q & ~fifo_empty;
      end
   end
   assign irq_en = irq_en_q;
   assign irq    = irq_q;
`else
   assign irq_en = 1'b0;
`endif

   // Read mux: samples state before any same-cycle write takes effect
   always_comb begin
      rdata_d = '0;
      if (sel_key) begin
         if (!fifo_empty) begin
            rdata_d[KEY_VALID_BIT] = 1'b1;
            rdata_d[3:0]           = fifo_dout;
         end
      end else if (sel_status) begin
         rdata_d[STAT_EMPTY]                  = fifo_empty;
         rdata_d[STAT_FULL]                   = fifo_full;
         rdata_d[STAT_OVF]                    = ovf_q;
         rdata_d[STAT_IRQ_EN]                 = irq_en;
         rdata_d[STAT_COUNT_LSB +: CNT_W]     = fifo_count;
      end else if (sel_dsel) begin
         rdata_d[DSEL_W-1:0] = dsel_q;
      end else if (sel_ddata) begin
         rdata_d[7:0] = digits_flat[{dsel_q, 3'b000} +: 8];
      end else if (sel_dot) begin
         rdata_d[0] = dot_q;
      end else if (sel_ctrl) begin
         rdata_d[CTRL_BLANK] = blank_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         dsel_q  <= '0;
         dot_q   <= 1'b0;
         blank_q <= 1'b0;
      end else begin
         dout_q <= readEnable ? rdata_d : '0;

         // A lost event in the same cycle as a clear is still reported
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end else if (wr_status && din[STAT_OVF]) begin
            ovf_q <= 1'b0;
         end

         if (wr_dsel) begin
            dsel_q <= (din >= DATA_W'(N_DIGITS)) ? '0 : din[DSEL_W-1:0];
         end else if (wr_ddata) begin
            dsel_q <= (dsel_q == DSEL_W'(N_DIGITS - 1)) ? '0 : dsel_q + 1'b1;
         end

         if (wr_dot)  dot_q   <= din[0];
         if (wr_ctrl) blank_q <= din[CTRL_BLANK];
      end
   end

   assign dout = dout_q;
   assign dot  = dot_q;

endmodule

// File: tb/tb_peripheral_hub.sv
module tb_peripheral_hub;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 3;
   localparam int N_DIGITS = 11;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [ADDR_W-1:0]     address = '0;
   logic [DATA_W-1:0]     din = '0;
   logic                  writeEnable = 1'b0;
   logic                  readEnable = 1'b0;
   logic [DATA_W-1:0]     dout;
   logic                  key_valid = 1'b0;
   logic [3:0]            key_code = '0;
   logic [8*N_DIGITS-1:0] segs;
   logic                  dot;
`ifdef PERIPH_IRQ_EN
   logic                  irq;
`endif

   peripheral_hub #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_DIGITS(N_DIGITS), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .rst(rst), .address(address), .din(din),
      .writeEnable(writeEnable), .readEnable(readEnable), .dout(dout),
      .key_valid(key_valid), .key_code(key_code), .segs(segs), .dot(dot)
`ifdef PERIPH_IRQ_EN
      , .irq(irq)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic        re;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic        kv;
      logic [3:0]  kc;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Add one table entry: bus op, keypad pulse, expected dout after the cycle
   task automatic add(input logic we, input logic re, input logic [2:0] a, input logic [31:0] d,
                      input logic kv, input logic [3:0] kc, input logic [31:0] exp);
      vec_t v;
      v.we = we; v.re = re; v.addr = a; v.wdata = d; v.kv = kv; v.kc = kc; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp);
      add(1'b0, 1'b1, a, 32'h0, 1'b0, 4'h0, exp);
   endtask
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      add(1'b1, 1'b0, a, d, 1'b0, 4'h0, 32'h0);
   endtask
   task automatic push(input logic [3:0] c);
      add(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, c, 32'h0);
   endtask

   task automatic drive(input vec_t v);
      writeEnable = v.we; readEnable = v.re; address = v.addr;
      din = v.wdata; key_valid = v.kv; key_code = v.kc;
   endtask

   task automatic idle();
      writeEnable = 1'b0; readEnable = 1'b0; key_valid = 1'b0;
   endtask

   // Drive for one cycle, then sample dout just after the edge
   task automatic apply(input vec_t v, input string name);
      drive(v);
      @(posedge clk);
      #1;
      idle();
      check(name, dout, v.exp);
      $display("vec %s we=%0d re=%0d a=%0d d=%0h kv=%0d kc=%0h dout=%0h", name,
               v.we, v.re, v.addr, v.wdata, v.kv, v.kc, dout);
   endtask

   task automatic check_segs(input string name, input logic [7:0] d0, input logic [7:0] d10);
      logic [8*N_DIGITS-1:0] exp;
      for (int i = 0; i < N_DIGITS; i++) exp[8*i +: 8] = 8'hFF;
      exp[7:0]   = d0;
      exp[87:80] = d10;
      check(name, segs, exp);
   endtask

   initial begin
      vec_t v;
      // ---------------- FIFO behaviour ----------------
      rd(3'd1, 32'h1);                      // reset STATUS
      push(4'h3); push(4'h7); push(4'hC);   // dout back to 0 after read
      rd(3'd1, 32'h0300);
      rd(3'd0, 32'h103); rd(3'd0, 32'h107); rd(3'd0, 32'h10C);
      rd(3'd0, 32'h0);                      // empty read, no pop
      rd(3'd1, 32'h1);
      push(4'h3);
      for (int i = 1; i <= 7; i++) push(4'(i));
      push(4'h8);                           // ninth push overflows
      rd(3'd1, 32'h0806);
      add(1'b1, 1'b1, 3'd1, 32'h4, 1'b0, 4'h0, 32'h0806); // read sees pre-clear
      rd(3'd1, 32'h0802);
      add(1'b0, 1'b1, 3'd0, 32'h0, 1'b1, 4'h9, 32'h103);  // full: pop + push
      rd(3'd1, 32'h0802);
      rd(3'd0, 32'h101);
      add(1'b1, 1'b0, 3'd5, 32'h1, 1'b1, 4'h5, 32'h0);    // flush beats push
      rd(3'd1, 32'h1);
      rd(3'd5, 32'h0);                                     // flush self-clears
      add(1'b0, 1'b1, 3'd0, 32'h0, 1'b1, 4'h5, 32'h0);    // empty: read 0, push lands
      rd(3'd1, 32'h0100);
      rd(3'd0, 32'h105);
      wr(3'd0, 32'h1FF);                                   // KEY writes ignored
      rd(3'd1, 32'h1);
      add(1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF, 1'b0, 4'h0, 32'h0);
      rd(3'd7, 32'h0);
      // ---------------- display ----------------
      wr(3'd2, 32'd10); rd(3'd2, 32'd10);
      wr(3'd3, 32'h3F); wr(3'd3, 32'h06);
      rd(3'd2, 32'd1);                                     // wrapped 10 -> 0 -> 1
      wr(3'd2, 32'd11); rd(3'd2, 32'd0);                  // out-of-range -> 0
      rd(3'd3, 32'h06); rd(3'd3, 32'h06);                 // read leaves DSEL alone
      rd(3'd2, 32'd0);
      wr(3'd2, 32'd10); rd(3'd3, 32'h3F); rd(3'd2, 32'd10);
      wr(3'd4, 32'h1); rd(3'd4, 32'h1);

      // ---------------- reset state ----------------
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_dout", dout, 0);
      check("reset_dot", dot, 0);
      check_segs("reset_segs", 8'hFF, 8'hFF);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("t%0d", i));

      check("dot_set", dot, 1'b1);
      check_segs("segs_digits", 8'h06, 8'h3F);

      // Blank hides digits without losing them
      v = '{we: 1'b1, re: 1'b0, addr: 3'd5, wdata: 32'h2, kv: 1'b0, kc: 4'h0, exp: 32'h0};
      apply(v, "blank_on");
      check_segs("segs_blank", 8'hFF, 8'hFF);
      v = '{we: 1'b0, re: 1'b1, addr: 3'd5, wdata: 32'h0, kv: 1'b0, kc: 4'h0, exp: 32'h2};
      apply(v, "ctrl_rd");
      v = '{we: 1'b1, re: 1'b0, addr: 3'd5, wdata: 32'h0, kv: 1'b0, kc: 4'h0, exp: 32'h0};
      apply(v, "blank_off");
      check_segs("segs_restored", 8'h06, 8'h3F);

      // Reset mid-operation with a pending KEY read
      v = '{we: 1'b0, re: 1'b0, addr: 3'd0, wdata: 32'h0, kv: 1'b1, kc: 4'h4, exp: 32'h0};
      apply(v, "pre_rst_push");
      readEnable = 1'b1; address = 3'd0; rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; idle();
      check("rst_dout", dout, 0);
      check_segs("rst_segs", 8'hFF, 8'hFF);
      check("rst_dot", dot, 0);
      v = '{we: 1'b0, re: 1'b1, addr: 3'd1, wdata: 32'h0, kv: 1'b0, kc: 4'h0, exp: 32'h1};
      apply(v, "rst_status");

`ifdef PERIPH_IRQ_EN
      v = '{we: 1'b1, re: 1'b0, addr: 3'd1, wdata: 32'h8, kv: 1'b0, kc: 4'h0, exp: 32'h0};
      apply(v, "irq_en_wr");
      v = '{we: 1'b0, re: 1'b1, addr: 3'd1, wdata: 32'h0, kv: 1'b0, kc: 4'h0, exp: 32'h9};
      apply(v, "irq_en_rd");
      check("irq_idle", irq, 0);
      key_valid = 1'b1; key_code = 4'h2;
      @(posedge clk); #1; idle();
      check("irq_c1", irq, 0);
      @(posedge clk); #1;
      check("irq_c2", irq, 1);
      v = '{we: 1'b0, re: 1'b1, addr: 3'd0, wdata: 32'h0, kv: 1'b0, kc: 4'h0, exp: 32'h102};
      apply(v, "irq_pop");
      check("irq_pop_edge", irq, 1);
      @(posedge clk); #1;
      check("irq_clear", irq, 0);
`else
      v = '{we: 1'b1, re: 1'b0, addr: 3'd1, wdata: 32'h8, kv: 1'b0, kc: 4'h0, exp: 32'h0};
      apply(v, "irqen_wr_ignored");
      v = '{we: 1'b0, re: 1'b1, addr: 3'd1, wdata: 32'h0, kv: 1'b0, kc: 4'h0, exp: 32'h1};
      apply(v, "irqen_rd_zero");
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
